// File: rtl/packet_arbitration_multiplexer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packet_arbitration_multiplexer_pkg
// Purpose  : Shared definitions for the arbiter family: FSM state encoding
//            and the index-width helper used for channel-number ports.
// Revision : 1.0 - initial release
// ============================================================================
package packet_arbitration_multiplexer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE   = 1'b0;
  localparam state_t LOCKED = 1'b1;

  // Width of a binary channel index; never less than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_arbitration_multiplexer_onehot_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : onehot_to_binary
// Purpose  : Converts a one-hot vector into a binary index. On multi-hot input
//            the lowest set bit wins.
// Ports    : onehot - input vector (SIZE bits)
//            index  - binary index of the lowest set bit (0 when none set)
//            valid  - at least one bit of onehot is set
// Revision : 1.0 - initial release
// ============================================================================
module onehot_to_binary
  import packet_arbitration_multiplexer_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0]               onehot,
  output logic [index_width(SIZE)-1:0] index,
  output logic                          valid
);

  localparam int IW = index_width(SIZE);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    index = '0;
    valid = |onehot;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        index = i[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_arbitration_multiplexer.sv
`default_nettype none
// ============================================================================
// Module   : packet_arbitration_multiplexer
// Purpose  : Multiplexes SIZE packet channels onto one registered output,
//            driven by an external arbiter's grant. Once a multi-beat packet
//            starts, the channel is locked until its last beat regardless of
//            the arbiter's grant.
// Ports    : clock, reset                  - clock / async active-high reset
//            write_valid/data/last/ready   - per-channel input beats
//            requests, grant               - arbiter interface
//            read_valid/data/last/channel  - registered output beat
//            read_ready                    - downstream accept
// Revision : 1.0 - initial release
// ============================================================================
module packet_arbitration_multiplexer
  import packet_arbitration_multiplexer_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [SIZE-1:0]               write_valid,
  input  logic [SIZE*WIDTH-1:0]         write_data,
  input  logic [SIZE-1:0]               write_last,
  output logic [SIZE-1:0]               write_ready,
  output logic [SIZE-1:0]               requests,
  input  logic [SIZE-1:0]               grant,
  output logic                          read_valid,
  output logic [WIDTH-1:0]              read_data,
  output logic                          read_last,
  output logic [index_width(SIZE)-1:0] read_channel,
  input  logic                          read_ready
);

  localparam int IW = index_width(SIZE);

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   locked_index;
  logic [IW-1:0]   grant_index;
  logic            grant_any;
  logic [IW-1:0]   selected;
  logic            select_ok;
  logic            can_accept;
  logic            transfer;
  logic            beat_last;
  logic [WIDTH-1:0] beat_data;

  onehot_to_binary #(
    .SIZE (SIZE)
  ) u_grant_decode (
    .onehot (grant),
    .index  (grant_index),
    .valid  (grant_any)
  );

  assign can_accept = !read_valid || read_ready;
  assign transfer   = |(write_valid & write_ready);
  assign beat_last  = write_last[selected];
  assign beat_data  = write_data[selected*WIDTH +: WIDTH];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      locked_index <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && transfer && !beat_last) begin
        locked_index <= selected;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer && !beat_last) state_next = LOCKED;
      LOCKED:  if (transfer && beat_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: while idle the arbiter picks; a grant to a channel that is
  // not presenting a beat selects nothing. While locked the grant is ignored.
  always_comb begin
    requests    = '0;
    selected    = locked_index;
    select_ok   = 1'b1;
    write_ready = '0;
    if (state == IDLE) begin
      requests  = write_valid;
      selected  = grant_index;
      select_ok = grant_any && write_valid[grant_index];
    end
    if (!reset && select_ok && can_accept) begin
      write_ready[selected] = 1'b1;
    end
  end

  // Single-stage output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_valid   <= 1'b0;
      read_data    <= '0;
      read_last    <= 1'b0;
      read_channel <= '0;
    end else if (transfer) begin
      read_valid   <= 1'b1;
      read_data    <= beat_data;
      read_last    <= beat_last;
      read_channel <= selected;
    end else if (read_ready) begin
      read_valid   <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // A multi-hot grant is an upstream protocol error; the decoder still
  // resolves it to the lowest channel.
  always @(posedge clock) begin
    if (!reset && state == IDLE) begin
      assert ($onehot0(grant))
        else $warning("multi-hot grant %b", grant);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/packet_arbitration_multiplexer.md
Name: packet_arbitration_multiplexer

Overview:
- Sits directly downstream of round_robin_arbiter (or static_priority_arbiter).
- Presents per-channel valid as the arbiter's requests and consumes the arbiter's one-hot grant.
- Routes the granted channel's valid/data/last beats into a single registered output channel.
- Holds the selected channel for the whole multi-beat packet, even though the upstream arbiter's grant keeps moving every cycle.

Parameters:
SIZE, 4, number of input channels; must be ≥2.
WIDTH, 8, data width per beat.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
write_valid  input  SIZE  per-channel beat valid.
write_data  input  SIZE*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
write_last  input  SIZE  per-channel end-of-packet flag.
write_ready  output  SIZE  per-channel beat accept.
requests  output  SIZE  request vector to the arbiter.
grant  input  SIZE  one-hot (or zero) grant from the arbiter, combinational in requests.
read_valid  output  1  output beat valid (registered).
read_data  output  WIDTH  output beat data (registered).
read_last  output  1  output end-of-packet (registered).
read_channel  output  CLOG2(SIZE)  source channel index of the output beat (registered).
read_ready  input  1  downstream accept.

Behaviour:
- Clock/reset: single clock domain. Reset is asynchronous, active-high, on port reset, with no synchronous clear.
- Reset values:
  - read_valid=0, read_last=0, read_data=0, read_channel=0.
  - state=IDLE, locked_index=0.
  - write_ready=0 during reset.
- can_accept = !read_valid || read_ready. The output register is a single stage, so back-to-back beats sustain full throughput while read_ready=1.
- State machine, two states:
  - IDLE:
    - requests = write_valid.
    - selected = index of the grant bit, only if that bit is also set in write_valid; otherwise there is no selection.
    - write_ready[selected] = can_accept; all other write_ready bits are 0.
    - On a transfer (write_valid&write_ready) with write_last=0: go to LOCKED and set locked_index=selected.
    - On a transfer with write_last=1 (single-beat packet): stay in IDLE.
  - LOCKED:
    - requests = 0, grant is ignored, selected = locked_index.
    - write_ready[locked_index] = can_accept; all other bits are 0.
    - On a transfer with write_last=1: return to IDLE.
    - Otherwise: stay in LOCKED. Idle gaps (write_valid low) inside a packet keep the lock.
- Transfer:
  - On each accepted beat, the output register loads data, last, selected index, and valid=1.
  - If can_accept and there is no transfer, read_valid is cleared when read_ready=1.
  - If read_valid=1 and read_ready=0, the output register holds its contents stable.
- Latency: one cycle from input handshake to read_valid.
- Grant with more than one bit set is a protocol error: use the lowest-index set bit and flag it with a simulation-only assertion.
- A grant bit for a channel whose write_valid=0 is ignored, with no transfer and no state change.
- Simultaneous events:
  - The last beat of a packet and the output drain can occur in the same cycle.
  - The new arbitration takes effect the cycle after the return to IDLE; there is no same-cycle re-arbitration.
- Reset mid-packet:
  - The lock is abandoned and the output beat is dropped.
  - The upstream source must restart the packet.

Decomposition:
- Shared header (arbiter family .vh): state encoding localparams IDLE=0, LOCKED=1. CLOG2 comes from common.vh.
- One sub-module: onehot_to_binary (SIZE parameter, lowest-index priority on multi-hot input, plus a valid output). Reuse it in the arbiter family.
- The output register stays inline.

Test Plan:
- Single-beat packets (SIZE=4): write_valid=4'b0101, last=1, grant=4'b0001 then 4'b0100, read_ready=1 -> read_channel 0 then 2 on consecutive cycles. write_ready pulses bit0 then bit2. State stays IDLE.
- Lock hold: channel 1 sends a 3-beat packet (data 0x11, 0x12, 0x13, last on the 3rd); grant rotates every cycle; channel 3 is also valid -> output is 0x11, 0x12, 0x13 with read_channel=1 throughout and requests=0 during LOCKED. Channel 3 is granted only after the 0x13 beat.
- Backpressure: read_ready=0 for 3 cycles with read_valid=1 -> read_data/read_last/read_channel stay stable and write_ready=0. Releasing read_ready -> the next beat is accepted in the same cycle.
- Bubble inside packet: channel 2 drops write_valid for 2 cycles mid-packet while channel 0 is valid and granted -> channel 0 is not served and the lock stays on channel 2 until its last beat.
- Bad grant: grant=4'b1010 with write_valid=4'b1010 -> channel 1 is selected and the assertion fires. Grant=4'b0100 with write_valid=4'b0001 -> no transfer.
- Reset mid-packet: assert reset asynchronously in LOCKED with read_valid=1 -> read_valid=0 immediately and state IDLE after deassertion. A fresh packet from another channel is accepted normally.
